// File: rtl/dp_sequencer_if.sv
// Shared ALU opcode type and the decode/ALU/register-file bundle driven by dp_sequencer.
// The slave modport is the sequencer's view; the master modport is its environment.
package dp_sequencer_pkg;
    typedef enum logic [3:0] {
        ALU_AND, ALU_XOR, ALU_SUB, ALU_SUB_REVERSED,
        ALU_ADD, ALU_ADC, ALU_SBC, ALU_SBC_REVERSED,
        ALU_TEST, ALU_TEST_EXCLUSIVE, ALU_CMP, ALU_CMP_NEG,
        ALU_OR, ALU_MOV, ALU_BIT_CLEAR, ALU_NOT
    } alu_op_t;

    localparam logic [1:0] SH_LSL = 2'd0;
    localparam logic [1:0] SH_LSR = 2'd1;
    localparam logic [1:0] SH_ASR = 2'd2;
    localparam logic [1:0] SH_ROR = 2'd3;
endpackage

interface dp_sequencer_if #(parameter int unsigned NUM_REGS = 16);
    import dp_sequencer_pkg::*;
    localparam int unsigned AW = $clog2(NUM_REGS);

    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic          flush;
    logic [3:0]    cpsr_flags;
    logic [AW-1:0] rn_addr;
    logic [AW-1:0] rm_addr;
    logic [AW-1:0] rs_addr;
    logic [31:0]   rn_data;
    logic [31:0]   rm_data;
    logic [31:0]   rs_data;
    alu_op_t       alu_op;
    logic [31:0]   op_a;
    logic          latch_op_b;
    logic          use_op_b_latch;
    logic          disable_op_b;
    logic [31:0]   sh_value;
    logic [1:0]    sh_type;
    logic [7:0]    sh_amount;
    logic          sh_by_reg;
    logic [31:0]   alu_result;
    logic [3:0]    alu_flags;
    logic          rd_we;
    logic [AW-1:0] rd_addr;
    logic [31:0]   rd_data;
    logic          flags_we;
    logic [3:0]    flags_out;
    logic          pc_write;
    logic          done;

    modport slave (
        input  instr_valid, instr, flush, cpsr_flags,
        input  rn_data, rm_data, rs_data, alu_result, alu_flags,
        output instr_ready, rn_addr, rm_addr, rs_addr, alu_op, op_a,
        output latch_op_b, use_op_b_latch, disable_op_b,
        output sh_value, sh_type, sh_amount, sh_by_reg,
        output rd_we, rd_addr, rd_data, flags_we, flags_out, pc_write, done
    );

    modport master (
        output instr_valid, instr, flush, cpsr_flags,
        output rn_data, rm_data, rs_data, alu_result, alu_flags,
        input  instr_ready, rn_addr, rm_addr, rs_addr, alu_op, op_a,
        input  latch_op_b, use_op_b_latch, disable_op_b,
        input  sh_value, sh_type, sh_amount, sh_by_reg,
        input  rd_we, rd_addr, rd_data, flags_we, flags_out, pc_write, done
    );
endinterface

// File: rtl/dp_sequencer.sv
// ARM data-processing sequencer: IDLE -> [SHIFT] -> EXEC, driving ALU/shifter and writeback.
// Define DP_SEQ_COND_EN to evaluate the condition field; otherwise every instruction is AL.
module dp_sequencer
    import dp_sequencer_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic           clk,
    input  logic           reset,
    dp_sequencer_if.slave  bus
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        from_shift_q, from_shift_d;
    logic        cond_ok_q, cond_ok_d;
    logic        cond_pass_c;

`ifdef DP_SEQ_COND_EN
    // Condition check against current NZCV, done at accept time.
    always_comb begin
        cond_pass_c = 1'b0;
        unique case (bus.instr[31:28])
            4'h0: cond_pass_c = bus.cpsr_flags[2];
            4'h1: cond_pass_c = !bus.cpsr_flags[2];
            4'h2: cond_pass_c = bus.cpsr_flags[1];
            4'h3: cond_pass_c = !bus.cpsr_flags[1];
            4'h4: cond_pass_c = bus.cpsr_flags[3];
            4'h5: cond_pass_c = !bus.cpsr_flags[3];
            4'h6: cond_pass_c = bus.cpsr_flags[0];
            4'h7: cond_pass_c = !bus.cpsr_flags[0];
            4'h8: cond_pass_c = bus.cpsr_flags[1] && !bus.cpsr_flags[2];
            4'h9: cond_pass_c = !bus.cpsr_flags[1] || bus.cpsr_flags[2];
            4'hA: cond_pass_c = (bus.cpsr_flags[3] == bus.cpsr_flags[0]);
            4'hB: cond_pass_c = (bus.cpsr_flags[3] != bus.cpsr_flags[0]);
            4'hC: cond_pass_c = !bus.cpsr_flags[2] && (bus.cpsr_flags[3] == bus.cpsr_flags[0]);
            4'hD: cond_pass_c = bus.cpsr_flags[2] || (bus.cpsr_flags[3] != bus.cpsr_flags[0]);
            4'hE: cond_pass_c = 1'b1;
            default: cond_pass_c = 1'b0;
        endcase
    end
`else
    assign cond_pass_c = 1'b1;
`endif

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        from_shift_d = from_shift_q;
        cond_ok_d    = cond_ok_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid && !bus.flush) begin
                    instr_d      = bus.instr;
                    cond_ok_d    = cond_pass_c;
                    from_shift_d = 1'b0;
                    // A failed condition skips the operand shift entirely.
                    if (cond_pass_c && !bus.instr[25] && bus.instr[4]) state_d = ST_SHIFT;
                    else                                             state_d = ST_EXEC;
                end
            end
            ST_SHIFT: begin
                if (bus.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d      = ST_EXEC;
                    from_shift_d = 1'b1;
                end
            end
            ST_EXEC: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            instr_q      <= '0;
            from_shift_q <= 1'b0;
            cond_ok_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            from_shift_q <= from_shift_d;
            cond_ok_q    <= cond_ok_d;
        end
    end

    logic    in_exec_c, in_shift_c, is_imm_c, no_wb_c, rd_is_pc_c, wb_ok_c;
    alu_op_t op_c;

    assign in_exec_c  = (state_q == ST_EXEC);
    assign in_shift_c = (state_q == ST_SHIFT);
    assign is_imm_c   = instr_q[25];
    assign op_c       = alu_op_t'(instr_q[24:21]);
    assign no_wb_c    = (op_c inside {ALU_TEST, ALU_TEST_EXCLUSIVE, ALU_CMP, ALU_CMP_NEG});
    assign rd_is_pc_c = (instr_q[15:12] == 4'd15);
    assign wb_ok_c    = in_exec_c && cond_ok_q && !bus.flush;

    assign bus.instr_ready    = (state_q == ST_IDLE);
    assign bus.rn_addr        = AW'(instr_q[19:16]);
    assign bus.rm_addr        = AW'(instr_q[3:0]);
    assign bus.rs_addr        = AW'(instr_q[11:8]);
    assign bus.rd_addr        = AW'(instr_q[15:12]);
    assign bus.alu_op         = op_c;
    assign bus.op_a           = bus.rn_data;
    assign bus.latch_op_b     = in_shift_c;
    assign bus.use_op_b_latch = in_exec_c && from_shift_q;
    assign bus.disable_op_b   = 1'b0;
    assign bus.sh_by_reg      = in_shift_c;

    // Immediate form is imm8 rotated right by twice the 4-bit rotate field.
    assign bus.sh_value  = is_imm_c ? {24'b0, instr_q[7:0]} : bus.rm_data;
    assign bus.sh_type   = is_imm_c ? SH_ROR : instr_q[6:5];
    assign bus.sh_amount = in_shift_c ? bus.rs_data[7:0]
                         : is_imm_c   ? {3'b000, instr_q[11:8], 1'b0}
                         :              8'(instr_q[11:7]);

    assign bus.rd_we     = wb_ok_c && !no_wb_c;
    assign bus.rd_data   = bus.alu_result;
    assign bus.pc_write  = wb_ok_c && !no_wb_c && rd_is_pc_c;
    assign bus.flags_we  = wb_ok_c && instr_q[20] && !rd_is_pc_c;
    assign bus.flags_out = bus.alu_flags;
    assign bus.done      = in_exec_c && !bus.flush;

    logic unused_bits_c;
    assign unused_bits_c = ^{instr_q[31:26], bus.rs_data[31:8], bus.cpsr_flags};
endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer with a small regfile/shifter/ALU model and a writeback scoreboard.
module tb_dp_sequencer;
    import dp_sequencer_pkg::*;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        fwe;
        logic [3:0]  fl;
        logic        pcw;
        logic        ul;
        int          lat;
    } exp_t;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    exp_t sbq[$];
    logic [31:0] regs [16];

    dp_sequencer_if #(.NUM_REGS(16)) bus ();
    dp_sequencer #(.NUM_REGS(16)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Register file reads combinationally.
    assign bus.rn_data = regs[bus.rn_addr];
    assign bus.rm_data = regs[bus.rm_addr];
    assign bus.rs_data = regs[bus.rs_addr];

    // Shifter, op_b capture and ALU model.
    logic [31:0] sh_out, opb_q, op_b, alu_res;
    logic [3:0]  alu_fl;

    always_comb begin
        sh_out = bus.sh_value;
        case (bus.sh_type)
            SH_LSL: sh_out = (bus.sh_amount >= 8'd32) ? 32'd0 : bus.sh_value << bus.sh_amount;
            SH_LSR: sh_out = (bus.sh_amount >= 8'd32) ? 32'd0 : bus.sh_value >> bus.sh_amount;
            SH_ASR: sh_out = $signed(bus.sh_value) >>> ((bus.sh_amount >= 8'd32) ? 8'd31 : bus.sh_amount);
            default: sh_out = (bus.sh_value >> bus.sh_amount[4:0]) |
                              (bus.sh_value << (6'd32 - {1'b0, bus.sh_amount[4:0]}));
        endcase
    end

    always_ff @(posedge clk) if (bus.latch_op_b) opb_q <= sh_out;

    assign op_b = bus.use_op_b_latch ? opb_q : (bus.disable_op_b ? 32'd0 : sh_out);

    function automatic logic [33:0] addc(input logic [31:0] x, input logic [31:0] y, input logic ci);
        logic [32:0] t;
        t = {1'b0, x} + {1'b0, y} + 33'(ci);
        return {(x[31] == y[31]) && (t[31] != x[31]), t};
    endfunction

    always_comb begin
        logic [33:0] r;
        logic        arith;
        r     = '0;
        arith = 1'b1;
        case (bus.alu_op)
            ALU_ADD, ALU_CMP_NEG: r = addc(bus.op_a, op_b, 1'b0);
            ALU_ADC:              r = addc(bus.op_a, op_b, bus.cpsr_flags[1]);
            ALU_SUB, ALU_CMP:     r = addc(bus.op_a, ~op_b, 1'b1);
            ALU_SBC:              r = addc(bus.op_a, ~op_b, bus.cpsr_flags[1]);
            ALU_SUB_REVERSED:     r = addc(op_b, ~bus.op_a, 1'b1);
            ALU_SBC_REVERSED:     r = addc(op_b, ~bus.op_a, bus.cpsr_flags[1]);
            default: begin
                arith = 1'b0;
                case (bus.alu_op)
                    ALU_AND, ALU_TEST:           r[31:0] = bus.op_a & op_b;
                    ALU_XOR, ALU_TEST_EXCLUSIVE: r[31:0] = bus.op_a ^ op_b;
                    ALU_OR:                      r[31:0] = bus.op_a | op_b;
                    ALU_MOV:                     r[31:0] = op_b;
                    ALU_BIT_CLEAR:               r[31:0] = bus.op_a & ~op_b;
                    default:                     r[31:0] = ~op_b;
                endcase
            end
        endcase
        alu_res = r[31:0];
        alu_fl  = {r[31], (r[31:0] == 32'd0),
                   arith ? r[32] : bus.cpsr_flags[1],
                   arith ? r[33] : bus.cpsr_flags[0]};
    end

    assign bus.alu_result = alu_res;
    assign bus.alu_flags  = alu_fl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic offer(input logic [31:0] w);
        bus.instr       = w;
        bus.instr_valid = 1'b1;
        tick();
        bus.instr_valid = 1'b0;
    endtask

    task automatic issue(input string tag, input logic [31:0] w, input exp_t e);
        sbq.push_back(e);
        offer(w);
        wait_done(tag);
    endtask

    // Waits (bounded) for done, then pops the oldest expectation and compares.
    task automatic wait_done(input string tag);
        int   cyc;
        exp_t e;
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 6) begin
            tick();
            cyc++;
        end
        e = sbq.pop_front();
        if (bus.done === 1'b1) begin
            chk({tag, ".lat"}, 32'(cyc), 32'(e.lat));
            chk({tag, ".rd_we"}, 32'(bus.rd_we), 32'(e.we));
            chk({tag, ".flags_we"}, 32'(bus.flags_we), 32'(e.fwe));
            chk({tag, ".pc_write"}, 32'(bus.pc_write), 32'(e.pcw));
            chk({tag, ".use_op_b_latch"}, 32'(bus.use_op_b_latch), 32'(e.ul));
            if (e.we) begin
                chk({tag, ".rd_addr"}, 32'(bus.rd_addr), 32'(e.addr));
                chk({tag, ".rd_data"}, bus.rd_data, e.data);
            end
            if (e.fwe) chk({tag, ".flags_out"}, 32'(bus.flags_out), 32'(e.fl));
            tick();
        end else begin
            chk({tag, ".done_timeout"}, 32'(bus.done), 32'd1);
        end
    endtask

    function automatic exp_t mk(input logic we, input logic [3:0] a, input logic [31:0] d,
                                input logic fwe, input logic [3:0] fl, input logic pcw,
                                input logic ul, input int lat);
        exp_t e;
        e.we = we; e.addr = a; e.data = d; e.fwe = fwe; e.fl = fl;
        e.pcw = pcw; e.ul = ul; e.lat = lat;
        return e;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk             = 1'b0;
        reset           = 1'b0;
        n_pass          = 0;
        n_total         = 0;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.flush       = 1'b0;
        bus.cpsr_flags  = 4'b0000;
        for (int i = 0; i < 16; i++) regs[i] = 32'h1000 + 32'(i);
        regs[0] = 32'd0;
        regs[3] = 32'd1;
        regs[4] = 32'd1;
        regs[5] = 32'd4;
        regs[7] = 32'h100;

        tick();
        tick();
        chk("rst.instr_ready", 32'(bus.instr_ready), 32'd1);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.rd_we", 32'(bus.rd_we), 32'd0);
        chk("rst.flags_we", 32'(bus.flags_we), 32'd0);
        chk("rst.latch_op_b", 32'(bus.latch_op_b), 32'd0);
        chk("rst.use_op_b_latch", 32'(bus.use_op_b_latch), 32'd0);
        reset = 1'b1;
        tick();

        // MOV r1,#0xFF
        issue("mov_imm", 32'hE3A010FF, mk(1, 4'd1, 32'hFF, 0, 4'h0, 0, 0, 1));

        // ADDS r2,r3,r4,LSL r5
        sbq.push_back(mk(1, 4'd2, 32'h11, 1, 4'b0000, 0, 1, 2));
        offer(32'hE0932514);
        chk("adds.latch_op_b", 32'(bus.latch_op_b), 32'd1);
        chk("adds.sh_by_reg", 32'(bus.sh_by_reg), 32'd1);
        chk("adds.sh_amount", 32'(bus.sh_amount), 32'd4);
        chk("adds.instr_ready", 32'(bus.instr_ready), 32'd0);
        chk("adds.done_t1", 32'(bus.done), 32'd0);
        wait_done("adds");

        // CMP r0,#0 : Z=1 C=1, no writeback
        issue("cmp", 32'hE3500000, mk(0, 4'd0, 32'd0, 1, 4'b0110, 0, 0, 1));

        // TST r0,r0 : logical op keeps C/V from CPSR
        issue("tst", 32'hE1100000, mk(0, 4'd0, 32'd0, 1, 4'b0100, 0, 0, 1));

        // MOV r6,r7,LSR #4
        sbq.push_back(mk(1, 4'd6, 32'h10, 0, 4'h0, 0, 0, 1));
        offer(32'hE1A06227);
        chk("lsr.sh_type", 32'(bus.sh_type), 32'(SH_LSR));
        chk("lsr.sh_amount", 32'(bus.sh_amount), 32'd4);
        chk("lsr.disable_op_b", 32'(bus.disable_op_b), 32'd0);
        wait_done("lsr");

        // MOV r8,#0x3F ROR 8
        issue("ror_imm", 32'hE3A0843F, mk(1, 4'd8, 32'h3F00_0000, 0, 4'h0, 0, 0, 1));

        // MOV pc,#4 and MOVS pc,#4 : pc_write, never flags
        issue("mov_pc", 32'hE3A0F004, mk(1, 4'd15, 32'd4, 0, 4'h0, 1, 0, 1));
        issue("movs_pc", 32'hE3B0F004, mk(1, 4'd15, 32'd4, 0, 4'h0, 1, 0, 1));

        // Condition codes with Z=0: EQ fails, NE passes, NV never
`ifdef DP_SEQ_COND_EN
        issue("moveq_z0", 32'h03A01001, mk(0, 4'd1, 32'd1, 0, 4'h0, 0, 0, 1));
        issue("movnv", 32'hF3A01001, mk(0, 4'd1, 32'd1, 0, 4'h0, 0, 0, 1));
        issue("addeq_reg_skip", 32'h00932514, mk(0, 4'd2, 32'h11, 0, 4'h0, 0, 0, 1));
`else
        issue("moveq_z0", 32'h03A01001, mk(1, 4'd1, 32'd1, 0, 4'h0, 0, 0, 1));
        issue("movnv", 32'hF3A01001, mk(1, 4'd1, 32'd1, 0, 4'h0, 0, 0, 1));
`endif
        issue("movne_z0", 32'h13A01002, mk(1, 4'd1, 32'd2, 0, 4'h0, 0, 0, 1));
        bus.cpsr_flags = 4'b0100;
        issue("moveq_z1", 32'h03A01003, mk(1, 4'd1, 32'd3, 0, 4'h0, 0, 0, 1));
        bus.cpsr_flags = 4'b0000;

        // Flush during SHIFT: no writes, back to IDLE, next instruction accepted at once
        offer(32'hE0932514);
        bus.flush = 1'b1;
        #1;
        chk("fl_shift.done", 32'(bus.done), 32'd0);
        chk("fl_shift.rd_we", 32'(bus.rd_we), 32'd0);
        tick();
        bus.flush = 1'b0;
        #1;
        chk("fl_shift.ready", 32'(bus.instr_ready), 32'd1);
        chk("fl_shift.done_after", 32'(bus.done), 32'd0);
        chk("fl_shift.rd_we_after", 32'(bus.rd_we), 32'd0);
        issue("after_flush", 32'hE3A010FF, mk(1, 4'd1, 32'hFF, 0, 4'h0, 0, 0, 1));

        // Flush during EXEC suppresses strobes
        offer(32'hE3B0100F);
        bus.flush = 1'b1;
        #1;
        chk("fl_exec.rd_we", 32'(bus.rd_we), 32'd0);
        chk("fl_exec.flags_we", 32'(bus.flags_we), 32'd0);
        chk("fl_exec.done", 32'(bus.done), 32'd0);
        tick();
        chk("fl_exec.ready", 32'(bus.instr_ready), 32'd1);

        // Flush in IDLE blocks the accept
        offer(32'hE3A010FF);
        chk("fl_idle.ready", 32'(bus.instr_ready), 32'd1);
        chk("fl_idle.done", 32'(bus.done), 32'd0);
        bus.flush = 1'b0;
        tick();
        chk("fl_idle.done_late", 32'(bus.done), 32'd0);

        // Async reset in EXEC
        offer(32'hE3A010FF);
        chk("rst_exec.rd_we_pre", 32'(bus.rd_we), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_exec.rd_we", 32'(bus.rd_we), 32'd0);
        chk("rst_exec.done", 32'(bus.done), 32'd0);
        chk("rst_exec.ready", 32'(bus.instr_ready), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        chk("rst_exec.ready_after", 32'(bus.instr_ready), 32'd1);
        chk("rst_exec.done_after", 32'(bus.done), 32'd0);
        issue("post_reset", 32'hE3A010FF, mk(1, 4'd1, 32'hFF, 0, 4'h0, 0, 0, 1));

        chk("sb.empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
